// File: rtl/frame_capture_ctrl_if.sv
// Signal bundle between the frame capture controller, the image sensor, the pixel FIFO
// and the host that starts/aborts captures.
interface frame_capture_ctrl_if;
    logic        start;
    logic        abort;
    logic        LVAL;
    logic        DVAL;
    logic [9:0]  pixel_in;
    logic        fifo_full;
    logic        SYS_RES_N;
    logic        FRAME_REQ;
    logic        fifo_wr_rst;
    logic        fifo_wr_en;
    logic [31:0] fifo_din;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic [18:0] pixel_count;
    logic [9:0]  line_count;

    // Controller side
    modport slave (
        input  start, abort, LVAL, DVAL, pixel_in, fifo_full,
        output SYS_RES_N, FRAME_REQ, fifo_wr_rst, fifo_wr_en, fifo_din,
        output busy, frame_done, overflow, pixel_count, line_count
    );

    // Host / sensor / FIFO side
    modport master (
        output start, abort, LVAL, DVAL, pixel_in, fifo_full,
        input  SYS_RES_N, FRAME_REQ, fifo_wr_rst, fifo_wr_en, fifo_din,
        input  busy, frame_done, overflow, pixel_count, line_count
    );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Sequences sensor reset, FIFO reset and frame request, then streams one frame of
// pixels into the FIFO with drop/overflow accounting and abort support.
module frame_capture_ctrl #(
    parameter int PIXELS_PER_LINE   = 648,
    parameter int LINES_PER_FRAME   = 488,
    parameter int SENSOR_RST_CYCLES = 16,
    parameter int FIFO_RST_CYCLES   = 4,
    parameter int REQ_CYCLES        = 2
) (
    input  logic CLK_OUT,
    input  logic Reset_N,
    frame_capture_ctrl_if.slave io_cap
);

    localparam int          FRAME_PIXELS    = PIXELS_PER_LINE * LINES_PER_FRAME;
    localparam logic [18:0] LAST_PIXEL_IDX  = 19'(FRAME_PIXELS - 1);
    localparam logic [15:0] SENSOR_RST_LAST = 16'(SENSOR_RST_CYCLES - 1);
    localparam logic [15:0] FIFO_RST_LAST   = 16'(FIFO_RST_CYCLES - 1);
    localparam logic [15:0] REQ_LAST        = 16'(REQ_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SENSOR_RST,
        FIFO_RST,
        REQ,
        CAPTURE,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_timer;
    logic        r_startPrev;
    logic        r_lvalPrev;
    logic        r_finalCycle;
    logic        r_sysResN;
    logic        r_frameReq;
    logic        r_fifoWrRst;
    logic        r_fifoWrEn;
    logic [31:0] r_fifoDin;
    logic        r_frameDone;
    logic        r_overflow;
    logic [18:0] r_pixelCount;
    logic [9:0]  r_lineCount;

    logic w_startRise;
    logic w_validPix;
    logic w_finalPix;
    logic w_writePix;
    logic w_dropPix;
    logic w_lineEnd;
    logic w_enterRst;
    logic w_sysResNNext;
    logic w_frameReqNext;
    logic w_fifoWrRstNext;

    assign w_startRise = io_cap.start & ~r_startPrev;
    assign w_validPix  = (r_state == CAPTURE) & io_cap.LVAL & io_cap.DVAL & ~io_cap.abort;
    assign w_finalPix  = w_validPix & (r_pixelCount == LAST_PIXEL_IDX);
    assign w_writePix  = w_validPix & ~io_cap.fifo_full;
    assign w_dropPix   = w_validPix & io_cap.fifo_full;
    assign w_enterRst  = (w_nextState == SENSOR_RST) & (r_state != SENSOR_RST);

    // The LVAL fall that closes the last line lands one cycle after the final pixel,
    // when the FSM is already in DONE, so that one cycle still counts line ends.
    assign w_lineEnd = r_lvalPrev & ~io_cap.LVAL & ~io_cap.abort
                     & ((r_state == CAPTURE) | r_finalCycle);

    // Next-state logic; control outputs are registered from the next state so each
    // pin changes on the same edge as the state it belongs to.
    always_comb begin
        w_nextState     = r_state;
        w_sysResNNext   = 1'b1;
        w_frameReqNext  = 1'b0;
        w_fifoWrRstNext = 1'b0;
        if (io_cap.abort) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_startRise) w_nextState = SENSOR_RST;
                end
                SENSOR_RST: begin
                    if (r_timer == SENSOR_RST_LAST) w_nextState = FIFO_RST;
                end
                FIFO_RST: begin
                    if (r_timer == FIFO_RST_LAST) w_nextState = REQ;
                end
                REQ: begin
                    if (r_timer == REQ_LAST) w_nextState = CAPTURE;
                end
                CAPTURE: begin
                    if (w_finalPix) w_nextState = DONE;
                end
                default: w_nextState = IDLE;
            endcase
        end
        w_sysResNNext   = (w_nextState != SENSOR_RST);
        w_frameReqNext  = (w_nextState == REQ);
        w_fifoWrRstNext = (w_nextState == FIFO_RST);
    end

    // State register with a per-state dwell timer that restarts on every transition.
    always_ff @(posedge CLK_OUT or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_nextState != r_state) begin
                r_timer <= '0;
            end else if (r_timer != '1) begin
                r_timer <= r_timer + 16'd1;
            end
        end
    end

    // Start history resets high so a start level held through reset is not a request.
    always_ff @(posedge CLK_OUT or negedge Reset_N) begin
        if (!Reset_N) begin
            r_startPrev  <= 1'b1;
            r_lvalPrev   <= 1'b0;
            r_sysResN    <= 1'b1;
            r_frameReq   <= 1'b0;
            r_fifoWrRst  <= 1'b1;
            r_fifoWrEn   <= 1'b0;
            r_fifoDin    <= '0;
            r_finalCycle <= 1'b0;
        end else begin
            r_startPrev  <= io_cap.start;
            r_lvalPrev   <= io_cap.LVAL;
            r_sysResN    <= w_sysResNNext;
            r_frameReq   <= w_frameReqNext;
            r_fifoWrRst  <= w_fifoWrRstNext;
            r_fifoWrEn   <= w_writePix;
            r_finalCycle <= w_finalPix;
            if (w_writePix) begin
                r_fifoDin <= {22'd0, io_cap.pixel_in};
            end
        end
    end

    // Frame statistics; cleared when a new capture begins and frozen in DONE/IDLE.
    always_ff @(posedge CLK_OUT or negedge Reset_N) begin
        if (!Reset_N) begin
            r_pixelCount <= '0;
            r_lineCount  <= '0;
            r_overflow   <= 1'b0;
            r_frameDone  <= 1'b0;
        end else if (w_enterRst) begin
            r_pixelCount <= '0;
            r_lineCount  <= '0;
            r_overflow   <= 1'b0;
            r_frameDone  <= 1'b0;
        end else begin
            if (w_validPix) r_pixelCount <= r_pixelCount + 19'd1;
            if (w_lineEnd)  r_lineCount  <= r_lineCount + 10'd1;
            if (w_dropPix)  r_overflow   <= 1'b1;
            if (w_finalPix) r_frameDone  <= 1'b1;
        end
    end

    assign io_cap.SYS_RES_N   = r_sysResN;
    assign io_cap.FRAME_REQ   = r_frameReq;
    assign io_cap.fifo_wr_rst = r_fifoWrRst;
    assign io_cap.fifo_wr_en  = r_fifoWrEn;
    assign io_cap.fifo_din    = r_fifoDin;
    assign io_cap.busy        = (r_state != IDLE) && (r_state != DONE);
    assign io_cap.frame_done  = r_frameDone;
    assign io_cap.overflow    = r_overflow;
    assign io_cap.pixel_count = r_pixelCount;
    assign io_cap.line_count  = r_lineCount;

endmodule
